uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of each byte lane and of uart_tx.
REQ-002 Parameter: N_REQ, 4, number of requesters (fixed 4 in this release).
REQ-003 Parameter: TIMEOUT, 1024, cycles WAIT may last before abort (used only with UART_ARB_TIMEOUT_EN).
REQ-004 Port: clk  in  1  single system clock, all state on rising edge.
REQ-005 Port: reset_  in  1  asynchronous, active-low reset.
REQ-006 Port: req  in  N_REQ  per-requester transmit request, level, held until matching gnt bit.
REQ-007 Port: req_data  in  N_REQ*DATA_W  byte per requester, lane i = bits [i*DATA_W +: DATA_W].
REQ-008 Port: tx_busy  in  1  UART transmitter busy, level.
REQ-009 Port: tx_done  in  1  UART transmitter finished byte, 1-cycle pulse.
REQ-010 Port: gnt  out  N_REQ  one-hot 1-cycle pulse, byte of requester i latched.
REQ-011 Port: send  out  1  1-cycle start pulse to UART transmitter.
REQ-012 Port: uart_tx  out  DATA_W  byte presented to UART transmitter, stable from send until tx_done.
REQ-013 Port: busy  out  1  high whenever state is WAIT.
REQ-014 Port: timeout_err  out  1  sticky flag, transmission aborted by timeout.

Function
REQ-015 FSM shall have two states: IDLE, WAIT.
REQ-016 In IDLE with any req bit high and tx_busy low, the arbiter shall select winner w, and on that edge register uart_tx <= lane w, gnt <= one-hot w, send <= 1, state <= WAIT.
REQ-017 Winner selection shall be round-robin: search req from index ptr upward modulo N_REQ, first set bit wins.
REQ-018 Grant-to-send latency shall be zero: gnt[w] and send shall be high in the same cycle, one cycle after the qualifying req sample.
REQ-019 gnt and send shall be high for exactly one cycle per grant, never otherwise.
REQ-020 In IDLE with tx_busy high, no grant shall issue; req shall remain pending.
REQ-021 In WAIT, a tx_done pulse shall return state to IDLE and set ptr <= (w+1) mod N_REQ.
REQ-022 tx_done received in IDLE shall be ignored.
REQ-023 req and tx_done high in the same WAIT cycle: tx_done is handled; the next grant shall issue no earlier than the cycle after IDLE is re-entered.
REQ-024 req deasserted before its gnt shall be treated as withdrawn; no byte sent.
REQ-025 uart_tx shall hold its value after WAIT until the next grant.
REQ-026 A requester whose req stays high after gnt shall be treated as a new request.

Reset
REQ-027 reset_ low shall immediately force state IDLE, ptr 0, gnt 0, send 0, uart_tx 0, busy 0, timeout_err 0, timeout counter 0.
REQ-028 reset_ asserted in WAIT shall abort the transfer; no tx_done is expected afterwards.
REQ-029 First grant after reset_ release shall favour requester 0.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: a counter shall clear on entry to WAIT, increment each WAIT cycle, and on reaching TIMEOUT without tx_done shall set timeout_err, return to IDLE and advance ptr as in REQ-021.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: no counter shall exist, timeout_err shall be tied 0, WAIT shall last until tx_done.
REQ-032 timeout_err shall clear only by reset_.

Verification
REQ-033 Reset: hold reset_ low 10 ns -> gnt=0000, send=0, uart_tx=0, busy=0, timeout_err=0.
REQ-034 Single: req=0001, lane0=42, tx_busy=0 -> next cycle gnt=0001, send=1, uart_tx=42; busy until tx_done pulse.
REQ-035 Fairness: req=1111, lanes 42/69/222/7, tx_done 5 cycles after each send -> sends 42,69,222,7 in order, each gnt one cycle.
REQ-036 Rotation: after grant to 2, req=1001 -> requester 3 (not 0) granted next.
REQ-037 Blocking: tx_busy=1 with req=0010 for 20 cycles -> no gnt/send; tx_busy=0 -> gnt=0010 next cycle.
REQ-038 Timeout (macro on, TIMEOUT=16): send, no tx_done -> after 16 WAIT cycles timeout_err=1, busy=0; reset_ mid-WAIT -> IDLE, timeout_err=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing one byte at a time to a UART transmitter.
// Optional WAIT-state abort counter is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [N_REQ-1:0]        gnt,
    output logic                    send,
    output logic [DATA_W-1:0]       uart_tx,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              send_q, send_d;
    logic [DATA_W-1:0] uart_tx_q, uart_tx_d;

    logic [PTR_W-1:0]  pick;
    logic              pick_vld;
    logic [PTR_W-1:0]  win_inc;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            int unsigned idx;
            idx = (ptr_q + i) % N_REQ;
            if (!pick_vld && req[idx[PTR_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        nxt     = (win_q + 1) % N_REQ;
        win_inc = nxt[PTR_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        gnt_d     = '0;
        send_d    = 1'b0;
        uart_tx_d = uart_tx_q;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld && !tx_busy) begin
                    state_d         = WAIT;
                    win_d           = pick;
                    gnt_d[pick]     = 1'b1;
                    send_d          = 1'b1;
                    uart_tx_d       = req_data[pick*DATA_W +: DATA_W];
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
                    ptr_d   = win_inc;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // cnt_q counts completed WAIT cycles, so WAIT lasts exactly TIMEOUT cycles.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    ptr_d         = win_inc;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            gnt_q     <= '0;
            send_q    <= 1'b0;
            uart_tx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            gnt_q     <= gnt_d;
            send_q    <= send_d;
            uart_tx_q <= uart_tx_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign send    = send_q;
    assign uart_tx = uart_tx_q;
    assign busy    = (state_q == WAIT);

endmodule
